// File: rtl/ethernet_header_pkg.sv
// Shared definitions for the Ethernet datapath blocks.
//   FIFO_DEPTH_DEFAULT : default byte depth of the frame FIFO
//   fifo_entry_t       : one stored FIFO entry {last, data}
//   wr_state_t         : frame FIFO write-side state
package ethernet_header_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 2048;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_ACTIVE  = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// The array has no reset; only locations that have been written are read back.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe, rd_data updates on the following edge
//   rd_addr : read address
//   rd_data : registered read data
module sdp_ram #(
  parameter  int WIDTH  = 9,
  parameter  int DEPTH  = 2048,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream byte FIFO. Only complete frames with a good FCS
// flag are forwarded; frames flagged bad on their last beat and frames that do
// not fit in storage are rolled back and counted.
//   clk, rst       : clock, synchronous active-low reset
//   s_axis_*       : input stream (tuser = FCS error, sampled with tlast)
//   s_axis_tready  : high whenever out of reset (source cannot be stalled)
//   m_axis_*       : output stream
//   drop_bad_cnt   : saturating count of frames dropped for FCS error
//   drop_ovf_cnt   : saturating count of frames dropped for overflow
module axis_frame_fifo
  import ethernet_header_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] drop_bad_cnt,
  output logic [CNT_W-1:0] drop_ovf_cnt
);

  localparam int                ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  wr_state_t       wr_state_r, wr_state_s;
  logic [ADDR_W:0] wr_ptr_r, wr_ptr_s;
  logic [ADDR_W:0] wr_commit_r, wr_commit_s;
  logic [ADDR_W:0] rd_ptr_r;
  logic [ADDR_W:0] occ_s;
  logic            full_s;
  logic            accept_s;
  logic            wr_en_s;
  logic            inc_bad_s, inc_ovf_s;
  fifo_entry_t     wr_entry_s, ram_q_s;
  logic            avail_s, rd_en_s, out_load_s;
  logic            ram_valid_r;
  logic            out_valid_r, out_last_r;
  logic [7:0]      out_data_r;
  logic [CNT_W-1:0] bad_cnt_r, ovf_cnt_r;

  // The source cannot be stalled, so ready simply mirrors reset release.
  assign s_axis_tready = rst;
  assign accept_s      = s_axis_tvalid & rst;

  // Occupancy never exceeds DEPTH, so the pointer-difference MSB alone marks full.
  assign occ_s  = wr_ptr_r - rd_ptr_r;
  assign full_s = occ_s[ADDR_W];

  assign wr_entry_s.last = s_axis_tlast;
  assign wr_entry_s.data = s_axis_tdata;

  // Write state and write-side pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_r  <= WR_IDLE;
      wr_ptr_r    <= {(ADDR_W+1){1'b0}};
      wr_commit_r <= {(ADDR_W+1){1'b0}};
    end else begin
      wr_state_r  <= wr_state_s;
      wr_ptr_r    <= wr_ptr_s;
      wr_commit_r <= wr_commit_s;
    end
  end

  // Write FSM next state.
  always_comb begin
    wr_state_s = wr_state_r;
    if (accept_s) begin
      case (wr_state_r)
        WR_IDLE, WR_ACTIVE: begin
          if (full_s) begin
            wr_state_s = s_axis_tlast ? WR_IDLE : WR_DISCARD;
          end else if (!s_axis_tlast) begin
            wr_state_s = WR_ACTIVE;
          end else begin
            wr_state_s = WR_IDLE;
          end
        end
        WR_DISCARD: begin
          if (s_axis_tlast) begin
            wr_state_s = WR_IDLE;
          end else begin
            wr_state_s = WR_DISCARD;
          end
        end
        default: wr_state_s = WR_IDLE;
      endcase
    end else begin
      wr_state_s = wr_state_r;
    end
  end

  // Write FSM outputs: RAM write, pointer advance/commit/rollback, drop events.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_ptr_s    = wr_ptr_r;
    wr_commit_s = wr_commit_r;
    inc_bad_s   = 1'b0;
    inc_ovf_s   = 1'b0;
    if (accept_s) begin
      case (wr_state_r)
        WR_IDLE, WR_ACTIVE: begin
          if (full_s) begin
            // Roll back to the last committed frame boundary.
            wr_ptr_s  = wr_commit_r;
            inc_ovf_s = 1'b1;
          end else if (!s_axis_tlast) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_ONE;
          end else if (!s_axis_tuser) begin
            wr_en_s     = 1'b1;
            wr_ptr_s    = wr_ptr_r + PTR_ONE;
            wr_commit_s = wr_ptr_r + PTR_ONE;
          end else begin
            wr_ptr_s  = wr_commit_r;
            inc_bad_s = 1'b1;
          end
        end
        WR_DISCARD: begin
          wr_en_s = 1'b0;
        end
        default: begin
          wr_ptr_s = wr_commit_r;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
    end
  end

  sdp_ram #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (wr_entry_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (ram_q_s)
  );

  // Two-stage read pipeline: RAM output register, then the output register.
  // A RAM read is issued whenever its result will have somewhere to go.
  always_comb begin
    avail_s    = (rd_ptr_r != wr_commit_r);
    out_load_s = ram_valid_r & (~out_valid_r | m_axis_tready);
    rd_en_s    = avail_s & (~ram_valid_r | out_load_s);
  end

  // Read pointer, RAM-stage valid and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r    <= {(ADDR_W+1){1'b0}};
      ram_valid_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= 8'h00;
    end else begin
      if (rd_en_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        ram_valid_r <= 1'b1;
      end else if (out_load_s) begin
        ram_valid_r <= 1'b0;
      end
      if (out_load_s) begin
        out_valid_r <= 1'b1;
        out_last_r  <= ram_q_s.last;
        out_data_r  <= ram_q_s.data;
      end else if (m_axis_tready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Saturating drop counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bad_cnt_r <= {CNT_W{1'b0}};
      ovf_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (inc_bad_s && (bad_cnt_r != CNT_MAX)) begin
        bad_cnt_r <= bad_cnt_r + CNT_ONE;
      end
      if (inc_ovf_s && (ovf_cnt_r != CNT_MAX)) begin
        ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
      end
    end
  end

  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tlast  = out_last_r;
  assign m_axis_tdata  = out_data_r;
  assign drop_bad_cnt  = bad_cnt_r;
  assign drop_ovf_cnt  = ovf_cnt_r;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Randomised, self-checking bench for axis_frame_fifo (DEPTH=64, CNT_W=2).
// The reference keeps a queue of bytes that must appear at the output, filled
// frame-by-frame from the forwarding rules, plus saturating drop counts.
module tb_axis_frame_fifo;

  localparam int DEPTH   = 64;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tuser;
  logic             s_axis_tready;
  logic [7:0]       m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic [CNT_W-1:0] drop_bad_cnt;
  logic [CNT_W-1:0] drop_ovf_cnt;

  axis_frame_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .drop_bad_cnt  (drop_bad_cnt),
    .drop_ovf_cnt  (drop_ovf_cnt)
  );

  always #5 clk = ~clk;

  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  logic [8:0] exp_q[$];
  int         bad_m = 0;
  int         ovf_m = 0;
  int         rmode = 0;   // 0: ready=1, 1: random, 2: 1,0,0,1 pattern, 3: ready=0

  task automatic check(input bit ok, input string name, input int act, input int exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Output ready generator.
  initial begin
    logic [3:0] pat;
    int         pi;
    pat = 4'b1001;
    pi  = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = 1'($urandom_range(0, 1));
        2: begin m_axis_tready = pat[pi]; pi = (pi + 1) % 4; end
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: every handshake is compared with the reference queue,
  // and a stalled beat must hold still until accepted.
  initial begin
    logic       hold;
    logic [8:0] hold_beat;
    logic [8:0] e;
    hold = 1'b0;
    hold_beat = 9'h000;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        hold = 1'b0;
      end else begin
        check(s_axis_tready == 1'b1, "s_tready_high", s_axis_tready, 1);
        if (hold)
          check(m_axis_tvalid && ({m_axis_tlast, m_axis_tdata} == hold_beat), "stall_stable",
                {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hold_beat});
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", {m_axis_tlast, m_axis_tdata}, 0);
          end else begin
            e = exp_q.pop_front();
            check({m_axis_tlast, m_axis_tdata} == e, "out_beat", {m_axis_tlast, m_axis_tdata}, e);
          end
        end
        hold      = m_axis_tvalid && !m_axis_tready;
        hold_beat = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic beat(input logic [7:0] d, input logic l, input logic u);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = 8'h00;
    end
  endtask

  // base < 0 selects random payload bytes.
  task automatic send_frame(input int len, input int base, input bit bad, input bit gaps);
    logic [8:0] beats[$];
    logic [7:0] d;
    logic       l;
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
      d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
      l = (i == len - 1);
      beats.push_back({l, d});
      beat(d, l, l ? bad : 1'($urandom_range(0, 1)));
    end
    if (len > DEPTH) begin
      if (ovf_m < CNT_MAX) ovf_m++;
    end else if (bad) begin
      if (bad_m < CNT_MAX) bad_m++;
    end else begin
      foreach (beats[k]) exp_q.push_back(beats[k]);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = 8'h00;
    exp_q.delete();
    bad_m = 0;
    ovf_m = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Wait until a frame of len bytes is guaranteed to fit.
  task automatic wait_room(input int len);
    int t;
    t = 0;
    while ((exp_q.size() + len > DEPTH) && (t < 3000)) begin idle(1); t++; end
    if (t >= 3000) check(1'b0, "room_timeout", exp_q.size(), DEPTH - len);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    idle(1);
    while ((exp_q.size() != 0) && (t < 3000)) begin idle(1); t++; end
    check(exp_q.size() == 0, {name, "_drained"}, exp_q.size(), 0);
    idle(4);
    @(negedge clk);
    check(m_axis_tvalid == 1'b0, {name, "_no_extra"}, m_axis_tvalid, 0);
  endtask

  task automatic check_counters(input string name);
    check(drop_bad_cnt == CNT_W'(bad_m), {name, "_bad_cnt"}, drop_bad_cnt, bad_m);
    check(drop_ovf_cnt == CNT_W'(ovf_m), {name, "_ovf_cnt"}, drop_ovf_cnt, ovf_m);
  endtask

  initial begin
    int len, r;
    rst = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tdata = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(s_axis_tready == 1'b0, "rst_s_tready", s_axis_tready, 0);
    check(m_axis_tvalid == 1'b0, "rst_m_tvalid", m_axis_tvalid, 0);
    check(m_axis_tlast == 1'b0, "rst_m_tlast", m_axis_tlast, 0);
    check(m_axis_tdata == 8'h00, "rst_m_tdata", m_axis_tdata, 0);
    check(drop_bad_cnt == 2'd0 && drop_ovf_cnt == 2'd0, "rst_counters",
          {drop_bad_cnt, drop_ovf_cnt}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Good 64-byte frame and store-and-forward latency.
    rmode = 0;
    for (int i = 0; i < 64; i++) exp_q.push_back({(i == 63), 8'(i)});
    for (int i = 0; i < 64; i++) beat(8'(i), (i == 63), 1'b0);
    idle(1);
    @(negedge clk);
    check(m_axis_tvalid == 1'b0, "lat_edge_n", m_axis_tvalid, 0);
    @(negedge clk);
    check(m_axis_tvalid == 1'b0, "lat_edge_n1", m_axis_tvalid, 0);
    @(negedge clk);
    check(m_axis_tvalid == 1'b1 && m_axis_tdata == 8'h00, "lat_edge_n2",
          {m_axis_tvalid, m_axis_tdata}, 9'h100);
    wait_drain("good64");
    check(drop_bad_cnt == 2'd0 && drop_ovf_cnt == 2'd0, "good64_counters",
          {drop_bad_cnt, drop_ovf_cnt}, 0);

    // Bad FCS frame followed by a good one.
    do_reset(1);
    send_frame(20, 8'h10, 1'b1, 1'b0);
    send_frame(10, 8'hA0, 1'b0, 1'b0);
    wait_drain("badfcs");
    check(drop_bad_cnt == 2'd1, "badfcs_bad_cnt", drop_bad_cnt, 1);
    check(drop_ovf_cnt == 2'd0, "badfcs_ovf_cnt", drop_ovf_cnt, 0);

    // Overflow with the output stalled.
    do_reset(1);
    rmode = 3;
    send_frame(100, 0, 1'b0, 1'b0);
    send_frame(8, 8'hB0, 1'b0, 1'b0);
    idle(5);
    @(negedge clk);
    check(drop_ovf_cnt == 2'd1, "ovf_ovf_cnt", drop_ovf_cnt, 1);
    check(drop_bad_cnt == 2'd0, "ovf_bad_cnt", drop_bad_cnt, 0);
    rmode = 0;
    wait_drain("ovf");

    // Back-pressure and address wrap: three 40-byte frames.
    rmode = 2;
    for (int k = 0; k < 3; k++) begin
      wait_room(40);
      send_frame(40, k * 40, 1'b0, 1'b0);
    end
    wait_drain("wrap");
    check_counters("wrap");

    // Reset in the middle of a frame with a stored frame pending.
    rmode = 3;
    send_frame(5, 8'hC0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) beat(8'(8'hD0 + i), 1'b0, 1'b0);
    do_reset(1);
    @(negedge clk);
    check(m_axis_tvalid == 1'b0, "midrst_m_tvalid", m_axis_tvalid, 0);
    check(drop_bad_cnt == 2'd0 && drop_ovf_cnt == 2'd0, "midrst_counters",
          {drop_bad_cnt, drop_ovf_cnt}, 0);
    rmode = 0;
    send_frame(10, 8'hDA, 1'b0, 1'b0);
    wait_drain("midrst_tail");

    // Randomised traffic.
    do_reset(2);
    rmode = 1;
    for (int f = 0; f < 60; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_frame($urandom_range(DEPTH + 1, DEPTH + 26), -1, 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        len = (r < 3) ? $urandom_range(1, 30) : $urandom_range(1, 40);
        wait_room(len);
        send_frame(len, -1, (r < 3), 1'b1);
      end
    end
    wait_drain("random");
    check_counters("random");

    // Counter saturation.
    do_reset(1);
    rmode = 0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(3, 8'h55, 1'b1, 1'b0);
      idle(2);
      @(negedge clk);
      check(drop_bad_cnt == CNT_W'((k < 3) ? k : 3), "sat_bad_cnt", drop_bad_cnt, (k < 3) ? k : 3);
    end
    check(drop_bad_cnt == 2'd3, "sat_final", drop_bad_cnt, 3);
    check_counters("sat");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
